// File: rtl/led_scan_controller.sv
// HUB75 row-scan sequencer: paces AL422 reads against the pixel-pair strobe, then blanks, latches and steps row/PWM.
// Optional SCAN_FRAME_CNT_EN adds a 16-bit frame_cnt output counting PWM wraps.
module led_scan_controller #(
   parameter int COLS         = 64,
   parameter int ROW_BITS     = 4,
   parameter int BLANK_CYCLES = 2,
   parameter int RRST_CYCLES  = 4
) (
   input  logic                in_clk,
   input  logic                in_nrst,
   input  logic                enable,
   input  logic                pwm_cntr_strobe,
   output logic [5:0]          pwm_value,
   output logic [ROW_BITS-1:0] row_addr,
   output logic                led_lat,
   output logic                led_oe_n,
   output logic                al_re_n,
   output logic                al_rrst_n,
   output logic                frame_done
`ifdef SCAN_FRAME_CNT_EN
   ,
   output logic [15:0]         frame_cnt
`endif
);

   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int TMR_MAX = (BLANK_CYCLES > RRST_CYCLES) ? BLANK_CYCLES : RRST_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
   localparam logic [TMR_W-1:0]    RRST_LAST  = TMR_W'(RRST_CYCLES - 1);
   localparam logic [TMR_W-1:0]    BLANK_LAST = TMR_W'(BLANK_CYCLES - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST   = {ROW_BITS{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RRST    = 3'd1,
      S_SYNC    = 3'd2,
      S_SHIFT   = 3'd3,
      S_BLANK   = 3'd4,
      S_LATCH   = 3'd5,
      S_ADVANCE = 3'd6
   } state_t;

   state_t              r_state,       w_state;
   logic [COL_W-1:0]    r_col_cnt,     w_col_cnt;
   logic [TMR_W-1:0]    r_tmr,         w_tmr;
   logic [ROW_BITS-1:0] r_shift_row,   w_shift_row;
   logic [5:0]          r_pwm_value,   w_pwm_value;
   logic [ROW_BITS-1:0] r_row_addr,    w_row_addr;
   logic                r_led_lat,     w_led_lat;
   logic                r_led_oe_n,    w_led_oe_n;
   logic                r_al_re_n,     w_al_re_n;
   logic                r_al_rrst_n,   w_al_rrst_n;
   logic                r_frame_done,  w_frame_done;

   // State and output registers; every output is taken straight from a flop.
   always_ff @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         r_state      <= S_IDLE;
         r_col_cnt    <= '0;
         r_tmr        <= '0;
         r_shift_row  <= '0;
         r_pwm_value  <= 6'd0;
         r_row_addr   <= '0;
         r_led_lat    <= 1'b0;
         r_led_oe_n   <= 1'b1;
         r_al_re_n    <= 1'b1;
         r_al_rrst_n  <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_col_cnt    <= w_col_cnt;
         r_tmr        <= w_tmr;
         r_shift_row  <= w_shift_row;
         r_pwm_value  <= w_pwm_value;
         r_row_addr   <= w_row_addr;
         r_led_lat    <= w_led_lat;
         r_led_oe_n   <= w_led_oe_n;
         r_al_re_n    <= w_al_re_n;
         r_al_rrst_n  <= w_al_rrst_n;
         r_frame_done <= w_frame_done;
      end
   end

   // Next-state and next-output logic; outputs change on the edge that enters a state.
   always_comb begin
      w_state      = r_state;
      w_col_cnt    = r_col_cnt;
      w_tmr        = r_tmr;
      w_shift_row  = r_shift_row;
      w_pwm_value  = r_pwm_value;
      w_row_addr   = r_row_addr;
      w_led_lat    = 1'b0;
      w_led_oe_n   = r_led_oe_n;
      w_al_re_n    = r_al_re_n;
      w_al_rrst_n  = r_al_rrst_n;
      w_frame_done = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_led_oe_n = 1'b1;
            w_al_re_n  = 1'b1;
            if (enable) begin
               w_state     = S_RRST;
               w_al_rrst_n = 1'b0;
               w_tmr       = '0;
            end else begin
               w_state = S_IDLE;
            end
         end
         S_RRST: begin
            if (r_tmr == RRST_LAST) begin
               w_state     = S_SYNC;
               w_al_rrst_n = 1'b1;
            end else begin
               w_tmr = r_tmr + TMR_W'(1);
            end
         end
         S_SYNC: begin
            if (!enable) begin
               w_state    = S_IDLE;
               w_led_oe_n = 1'b1;
            end else if (pwm_cntr_strobe) begin
               w_state   = S_SHIFT;
               w_col_cnt = '0;
               w_al_re_n = 1'b0;
            end else begin
               w_state = S_SYNC;
            end
         end
         S_SHIFT: begin
            // Blanking starts on the edge after the last column so the panel never shows a half-shifted row.
            if (pwm_cntr_strobe) begin
               if (r_col_cnt == COL_LAST) begin
                  w_state    = S_BLANK;
                  w_al_re_n  = 1'b1;
                  w_led_oe_n = 1'b1;
                  w_tmr      = '0;
               end else begin
                  w_col_cnt = r_col_cnt + COL_W'(1);
               end
            end else begin
               w_state = S_SHIFT;
            end
         end
         S_BLANK: begin
            if (r_tmr == BLANK_LAST) begin
               w_state    = S_LATCH;
               w_led_lat  = 1'b1;
               w_row_addr = r_shift_row;
            end else begin
               w_tmr = r_tmr + TMR_W'(1);
            end
         end
         S_LATCH: begin
            w_state    = S_ADVANCE;
            w_led_oe_n = 1'b0;
         end
         S_ADVANCE: begin
            w_shift_row = r_shift_row + ROW_BITS'(1);
            if (r_shift_row == ROW_LAST) begin
               w_pwm_value  = r_pwm_value + 6'd1;
               w_frame_done = (r_pwm_value == 6'd63);
               w_state      = S_RRST;
               w_al_rrst_n  = 1'b0;
               w_tmr        = '0;
            end else begin
               w_state = S_SYNC;
            end
         end
         default: begin
            w_state     = S_IDLE;
            w_led_oe_n  = 1'b1;
            w_al_re_n   = 1'b1;
            w_al_rrst_n = 1'b1;
         end
      endcase
   end

   assign pwm_value  = r_pwm_value;
   assign row_addr   = r_row_addr;
   assign led_lat    = r_led_lat;
   assign led_oe_n   = r_led_oe_n;
   assign al_re_n    = r_al_re_n;
   assign al_rrst_n  = r_al_rrst_n;
   assign frame_done = r_frame_done;

`ifdef SCAN_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Frame counter advances on the same edge that raises frame_done.
   always_ff @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         r_frame_cnt <= 16'd0;
      end else if (w_frame_done) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
         r_frame_cnt <= r_frame_cnt;
      end
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller (COLS=4, ROW_BITS=1): a cycle trace is checked against a
// table of hand-computed output vectors, plus enable-drop and mid-line reset sequences.
module tb_led_scan_controller;
   localparam int COLS         = 4;
   localparam int ROW_BITS     = 1;
   localparam int BLANK_CYCLES = 2;
   localparam int RRST_CYCLES  = 4;
   localparam int TRACE_LEN    = 3400;

   logic                in_clk = 1'b0;
   logic                in_nrst = 1'b0;
   logic                enable = 1'b0;
   logic                pwm_cntr_strobe = 1'b0;
   logic [5:0]          pwm_value;
   logic [ROW_BITS-1:0] row_addr;
   logic                led_lat;
   logic                led_oe_n;
   logic                al_re_n;
   logic                al_rrst_n;
   logic                frame_done;
`ifdef SCAN_FRAME_CNT_EN
   logic [15:0]         frame_cnt;
`endif

   led_scan_controller #(
      .COLS(COLS), .ROW_BITS(ROW_BITS), .BLANK_CYCLES(BLANK_CYCLES), .RRST_CYCLES(RRST_CYCLES)
   ) dut (
      .in_clk(in_clk), .in_nrst(in_nrst), .enable(enable), .pwm_cntr_strobe(pwm_cntr_strobe),
      .pwm_value(pwm_value), .row_addr(row_addr), .led_lat(led_lat), .led_oe_n(led_oe_n),
      .al_re_n(al_re_n), .al_rrst_n(al_rrst_n), .frame_done(frame_done)
`ifdef SCAN_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   initial forever #5 in_clk = ~in_clk;

   typedef struct {
      int                  cyc;
      logic                rrst_n;
      logic                re_n;
      logic                oe_n;
      logic                lat;
      logic [ROW_BITS-1:0] row;
      logic [5:0]          pwm;
      logic                fd;
   } vec_t;

   vec_t trace [TRACE_LEN];
   vec_t tbl [$];

   int tcyc = 0;
   bit run = 1'b0;
   bit en_cmd = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   int viol_lat = 0;
   int viol_rd = 0;
   int viol_row = 0;
   logic [ROW_BITS-1:0] prev_row = '0;

   // Stimulus driver: cycle index tcyc-1, strobe on every cycle with index%4==3.
   initial begin
      forever begin
         @(posedge in_clk);
         #1;
         if (run) begin
            enable = en_cmd;
            pwm_cntr_strobe = (tcyc % 4 == 3);
            tcyc = tcyc + 1;
         end else begin
            enable = 1'b0;
            pwm_cntr_strobe = 1'b0;
            tcyc = 0;
         end
      end
   end

   // Trace recorder and protocol monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge in_clk);
         if (run && tcyc > 0 && tcyc <= TRACE_LEN) begin
            trace[tcyc-1].cyc    = tcyc - 1;
            trace[tcyc-1].rrst_n = al_rrst_n;
            trace[tcyc-1].re_n   = al_re_n;
            trace[tcyc-1].oe_n   = led_oe_n;
            trace[tcyc-1].lat    = led_lat;
            trace[tcyc-1].row    = row_addr;
            trace[tcyc-1].pwm    = pwm_value;
            trace[tcyc-1].fd     = frame_done;
         end
         if (led_lat && !led_oe_n) viol_lat = viol_lat + 1;
         if (!al_re_n && !al_rrst_n) viol_rd = viol_rd + 1;
         if (row_addr != prev_row && !led_oe_n) viol_row = viol_row + 1;
         prev_row = row_addr;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] pk(input vec_t v);
      return 32'({v.rrst_n, v.re_n, v.oe_n, v.lat, v.row, v.pwm, v.fd});
   endfunction

   task automatic add(input int c, input logic rr, input logic re, input logic oe, input logic lt,
                      input logic [ROW_BITS-1:0] rw, input logic [5:0] pw, input logic fd);
      vec_t v;
      v.cyc = c; v.rrst_n = rr; v.re_n = re; v.oe_n = oe; v.lat = lt; v.row = rw; v.pwm = pw; v.fd = fd;
      tbl.push_back(v);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pwm_value"},  32'(pwm_value),  32'd0);
      check({tag, "_row_addr"},   32'(row_addr),   32'd0);
      check({tag, "_led_lat"},    32'(led_lat),    32'd0);
      check({tag, "_led_oe_n"},   32'(led_oe_n),   32'd1);
      check({tag, "_al_re_n"},    32'(al_re_n),    32'd1);
      check({tag, "_al_rrst_n"},  32'(al_rrst_n),  32'd1);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   function automatic int count_low_re(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (trace[i].re_n == 1'b0) n++;
      return n;
   endfunction

   initial begin
      int n_rrst;
      int n_lat;
      int n_fd;
      int n_oe;
      vec_t e;

      //   cyc   rrst re oe lat row pwm fd
      add(0,    1, 1, 1, 0, 0, 0, 0);
      add(1,    0, 1, 1, 0, 0, 0, 0);
      add(4,    0, 1, 1, 0, 0, 0, 0);
      add(5,    1, 1, 1, 0, 0, 0, 0);
      add(7,    1, 1, 1, 0, 0, 0, 0);
      add(8,    1, 0, 1, 0, 0, 0, 0);
      add(23,   1, 0, 1, 0, 0, 0, 0);
      add(24,   1, 1, 1, 0, 0, 0, 0);
      add(25,   1, 1, 1, 0, 0, 0, 0);
      add(26,   1, 1, 1, 1, 0, 0, 0);
      add(27,   1, 1, 0, 0, 0, 0, 0);
      add(28,   1, 1, 0, 0, 0, 0, 0);
      add(32,   1, 0, 0, 0, 0, 0, 0);
      add(47,   1, 0, 0, 0, 0, 0, 0);
      add(48,   1, 1, 1, 0, 0, 0, 0);
      add(50,   1, 1, 1, 1, 1, 0, 0);
      add(51,   1, 1, 0, 0, 1, 0, 0);
      add(52,   0, 1, 0, 0, 1, 1, 0);
      add(55,   0, 1, 0, 0, 1, 1, 0);
      add(56,   1, 1, 0, 0, 1, 1, 0);
      add(60,   1, 0, 0, 0, 1, 1, 0);
      add(78,   1, 1, 1, 1, 0, 1, 0);
      add(3327, 1, 1, 0, 0, 1, 63, 0);
      add(3328, 0, 1, 0, 0, 1, 0, 1);
      add(3329, 0, 1, 0, 0, 1, 0, 0);

      in_nrst = 1'b0;
      repeat (3) @(negedge in_clk);
      check_reset_values("reset");
      in_nrst = 1'b1;
      repeat (2) @(negedge in_clk);

      // 64 frames of 2 lines: first line timing, second line, PWM wrap.
      run = 1'b1;
      en_cmd = 1'b1;
      while (tcyc < 3345) @(negedge in_clk);
      foreach (tbl[k]) begin
         e = tbl[k];
         check($sformatf("trace_c%0d", e.cyc), pk(trace[e.cyc]), pk(e));
      end
      n_rrst = 0; n_lat = 0; n_fd = 0;
      for (int i = 0; i <= 20; i++) if (trace[i].rrst_n == 1'b0) n_rrst++;
      for (int i = 0; i <= 30; i++) if (trace[i].lat == 1'b1) n_lat++;
      for (int i = 0; i <= 3339; i++) if (trace[i].fd == 1'b1) n_fd++;
      check("rrst_low_cycles", 32'(n_rrst), 32'd4);
      check("re_low_cycles_line0", 32'(count_low_re(0, 26)), 32'd16);
      check("lat_pulses_line0", 32'(n_lat), 32'd1);
      check("frame_done_pulses", 32'(n_fd), 32'd1);
`ifdef SCAN_FRAME_CNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'd1);
`endif

      // Enable dropped during SHIFT of line 0.
      run = 1'b0;
      en_cmd = 1'b0;
      in_nrst = 1'b0;
      repeat (2) @(negedge in_clk);
      in_nrst = 1'b1;
      repeat (2) @(negedge in_clk);
      run = 1'b1;
      en_cmd = 1'b1;
      while (tcyc < 13) @(negedge in_clk);
      en_cmd = 1'b0;
      while (tcyc < 92) @(negedge in_clk);
      e.rrst_n = 1; e.re_n = 1; e.oe_n = 1; e.lat = 1; e.row = 0; e.pwm = 0; e.fd = 0;
      check("dis_latch_c26", pk(trace[26]), pk(e));
      e.oe_n = 0; e.lat = 0;
      check("dis_adv_c27", pk(trace[27]), pk(e));
      check("dis_sync_c28", pk(trace[28]), pk(e));
      e.oe_n = 1;
      check("dis_idle_c29", pk(trace[29]), pk(e));
      n_rrst = 0; n_oe = 0;
      for (int i = 29; i <= 90; i++) begin
         if (trace[i].rrst_n == 1'b0) n_rrst++;
         if (trace[i].oe_n == 1'b0) n_oe++;
      end
      check("dis_re_activity", 32'(count_low_re(29, 90)), 32'd0);
      check("dis_rrst_activity", 32'(n_rrst), 32'd0);
      check("dis_oe_low", 32'(n_oe), 32'd0);

      // Asynchronous reset in the middle of SHIFT, then restart.
      run = 1'b0;
      repeat (2) @(negedge in_clk);
      run = 1'b1;
      en_cmd = 1'b1;
      while (tcyc < 16) @(negedge in_clk);
      check("pre_reset_re_n", 32'(al_re_n), 32'd0);
      in_nrst = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge in_clk);
      in_nrst = 1'b1;
      @(negedge in_clk);
      check("restart_rrst_first", 32'(al_rrst_n), 32'd0);
      check("restart_re_idle", 32'(al_re_n), 32'd1);
      repeat (3) @(negedge in_clk);
      check("restart_rrst_last", 32'(al_rrst_n), 32'd0);
      @(negedge in_clk);
      check("restart_rrst_end", 32'(al_rrst_n), 32'd1);

      check("proto_lat_with_oe", 32'(viol_lat), 32'd0);
      check("proto_re_rrst_both_low", 32'(viol_rd), 32'd0);
      check("proto_row_change_oe_low", 32'(viol_row), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
